iob_sipo_deser: RTL and testbench

IOB_SIPO_DESER -- requirements
Module: iob_sipo_deser

---
 rtl/iob_sipo_deser_pkg.sv | 15 +
 rtl/iob_sipo_deser_if.sv | 34 +++
 rtl/iob_reg.sv | 32 +++
 rtl/iob_sipo_deser.sv | 115 +++++++++++
 tb/tb_iob_sipo_deser.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_sipo_deser_pkg.sv
// Shared types and helpers for the serial-in / parallel-out deserializer.
package iob_sipo_deser_pkg;

    // Output holding register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } holder_state_t;

    // Beat counter width: enough bits to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_sipo_deser_if.sv
// Bundle of the serial input and parallel output handshakes of iob_sipo_deser.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender keeps valid and data steady
// until that edge, and ready may depend combinationally on the other side.
interface iob_sipo_deser_if
    import iob_sipo_deser_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 1
);
    localparam int CNT_W = cnt_width(DATA_W / LANE_W);

    logic              s_valid;
    logic [LANE_W-1:0] s_data;
    logic              s_ready;
    logic              p_valid;
    logic [DATA_W-1:0] p_data;
    logic              p_ready;
    logic [CNT_W-1:0]  cnt;

    // Deserializer side.
    modport slave (
        input  s_valid, s_data, p_ready,
        output s_ready, p_valid, p_data, cnt
    );

    // Producer of beats and consumer of words.
    modport master (
        output s_valid, s_data, p_ready,
        input  s_ready, p_valid, p_data, cnt
    );

endinterface

// File: rtl/iob_reg.sv
// Generic register with async reset, clock enable, sync clear and load enable.
module iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] r_data;

    // Async reset wins; otherwise sync clear beats load, all gated by cke.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_data <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                r_data <= RST_VAL;
            end else if (en_i) begin
                r_data <= data_i;
            end
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/iob_sipo_deser.sv
// Serial-in / parallel-out deserializer: collects N beats of LANE_W bits into
// one DATA_W word and hands it out through a one-entry holding register.
module iob_sipo_deser
    import iob_sipo_deser_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int LANE_W    = 1,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int N         = DATA_W / LANE_W,
    localparam int CNT_W     = cnt_width(N)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [LANE_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              p_valid_o,
    output logic [DATA_W-1:0] p_data_o,
    input  logic              p_ready_i,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [DATA_W-1:0] w_acc;
    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_hold;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_at_last;
    logic              w_full;
    logic              w_beat;
    logic              w_last;

    holder_state_t     r_state;

    assign w_at_last = (w_cnt == LAST_CNT);
    assign w_full    = (r_state == ST_FULL);

    // Only the frame-closing beat can stall, and only when the finished word
    // would have nowhere to go; earlier beats never wait on the consumer.
    assign s_ready_o = cke_i & ~(w_at_last & w_full & ~p_ready_i);
    assign w_beat    = s_valid_i & s_ready_o;
    assign w_last    = w_beat & w_at_last;

    // Next accumulator value: shift the new lane in from the chosen end.
    generate
        if (N == 1) begin : g_single
            assign w_acc_nxt = s_data_i;
        end else if (MSB_FIRST) begin : g_msb
            assign w_acc_nxt = {w_acc[DATA_W-LANE_W-1:0], s_data_i};
        end else begin : g_lsb
            assign w_acc_nxt = {s_data_i, w_acc[DATA_W-1:LANE_W]};
        end
    endgenerate

    assign w_cnt_nxt = w_at_last ? '0 : (w_cnt + CNT_W'(1));

    iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_acc (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .en_i   (w_beat),
        .data_i (w_acc_nxt),
        .data_o (w_acc)
    );

    iob_reg #(.DATA_W(CNT_W), .RST_VAL('0)) u_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .en_i   (w_beat),
        .data_i (w_cnt_nxt),
        .data_o (w_cnt)
    );

    // The holder loads the word straight from the shift path so the finished
    // frame is visible one edge after its last beat.
    iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_hold (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .en_i   (w_last),
        .data_i (w_acc_nxt),
        .data_o (w_hold)
    );

    // Holder occupancy: a completing frame always leaves it FULL, a drain
    // with no new word empties it.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= ST_EMPTY;
        end else if (cke_i) begin
            if (rst_i) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: if (w_last) r_state <= ST_FULL;
                    ST_FULL:  if (!w_last && p_ready_i) r_state <= ST_EMPTY;
                    default:  r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign p_valid_o = w_full;
    assign p_data_o  = w_hold;
    assign cnt_o     = w_cnt;

endmodule

// File: tb/tb_iob_sipo_deser.sv
// Directed self-checking bench for iob_sipo_deser in two configurations:
// 8-bit word from 1-bit lanes MSB first, and 8-bit word from 2-bit lanes LSB first.
module tb_iob_sipo_deser;

    logic clk = 1'b0;
    logic cke0, arst0, rst0;
    logic cke1, arst1, rst1;

    int n_checks = 0;
    int n_fail   = 0;

    iob_sipo_deser_if #(.DATA_W(8), .LANE_W(1)) bus0 ();
    iob_sipo_deser_if #(.DATA_W(8), .LANE_W(2)) bus1 ();

    iob_sipo_deser #(.DATA_W(8), .LANE_W(1), .MSB_FIRST(1'b1)) dut0 (
        .clk_i     (clk),
        .cke_i     (cke0),
        .arst_i    (arst0),
        .rst_i     (rst0),
        .s_valid_i (bus0.s_valid),
        .s_data_i  (bus0.s_data),
        .s_ready_o (bus0.s_ready),
        .p_valid_o (bus0.p_valid),
        .p_data_o  (bus0.p_data),
        .p_ready_i (bus0.p_ready),
        .cnt_o     (bus0.cnt)
    );

    iob_sipo_deser #(.DATA_W(8), .LANE_W(2), .MSB_FIRST(1'b0)) dut1 (
        .clk_i     (clk),
        .cke_i     (cke1),
        .arst_i    (arst1),
        .rst_i     (rst1),
        .s_valid_i (bus1.s_valid),
        .s_data_i  (bus1.s_data),
        .s_ready_o (bus1.s_ready),
        .p_valid_o (bus1.p_valid),
        .p_data_o  (bus1.p_data),
        .p_ready_i (bus1.p_ready),
        .cnt_o     (bus1.cnt)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word on dut0, MSB first, one beat per cycle; s_valid stays high.
    task automatic send_word0(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = w[i];
            tick();
        end
    endtask

    task automatic test_reset();
        cke0 = 1'b1; rst0 = 1'b0; arst0 = 1'b1;
        cke1 = 1'b1; rst1 = 1'b0; arst1 = 1'b1;
        bus0.s_valid = 1'b0; bus0.s_data = '0; bus0.p_ready = 1'b1;
        bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.p_ready = 1'b1;
        #2;
        n_checks++; if (bus0.cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus0.cnt); end
        n_checks++; if (bus0.p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b want 0", bus0.p_valid); end
        n_checks++; if (bus0.p_data !== 8'h00) begin n_fail++; $display("FAIL reset_pdata: got %h want 00", bus0.p_data); end
        n_checks++; if (bus1.p_data !== 8'h00) begin n_fail++; $display("FAIL reset_pdata1: got %h want 00", bus1.p_data); end
        arst0 = 1'b0; arst1 = 1'b0;
        #1;
        n_checks++; if (bus0.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sready: got %b want 1", bus0.s_ready); end
        tick();
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hA5;
        bus0.p_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = w[7-i];
            #1;
            n_checks++; if (bus0.s_ready !== 1'b1) begin n_fail++; $display("FAIL msb_sready beat %0d: got %b want 1", i, bus0.s_ready); end
            tick();
            if (i < 7) begin
                n_checks++; if (bus0.cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL msb_cnt beat %0d: got %0d want %0d", i, bus0.cnt, i + 1); end
                n_checks++; if (bus0.p_valid !== 1'b0) begin n_fail++; $display("FAIL msb_early_pvalid beat %0d: got %b want 0", i, bus0.p_valid); end
            end
        end
        n_checks++; if (bus0.p_valid !== 1'b1) begin n_fail++; $display("FAIL msb_pvalid: got %b want 1", bus0.p_valid); end
        n_checks++; if (bus0.p_data !== 8'hA5) begin n_fail++; $display("FAIL msb_pdata: got %h want a5", bus0.p_data); end
        n_checks++; if (bus0.cnt !== 3'd0) begin n_fail++; $display("FAIL msb_cnt_wrap: got %0d want 0", bus0.cnt); end
        bus0.s_valid = 1'b0;
        tick();
        n_checks++; if (bus0.p_valid !== 1'b0) begin n_fail++; $display("FAIL msb_drain: got %b want 0", bus0.p_valid); end
    endtask

    task automatic test_lsb_first();
        logic [1:0] beats [4];
        beats[0] = 2'd1; beats[1] = 2'd1; beats[2] = 2'd0; beats[3] = 2'd2;
        bus1.p_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.s_valid = 1'b1;
            bus1.s_data  = beats[i];
            tick();
        end
        bus1.s_valid = 1'b0;
        n_checks++; if (bus1.p_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_pvalid: got %b want 1", bus1.p_valid); end
        n_checks++; if (bus1.p_data !== 8'h85) begin n_fail++; $display("FAIL lsb_pdata: got %h want 85", bus1.p_data); end
        n_checks++; if (bus1.cnt !== 2'd0) begin n_fail++; $display("FAIL lsb_cnt: got %0d want 0", bus1.cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        w = 8'h3C;
        bus0.p_ready = 1'b0;
        send_word0(8'hA5);
        for (int i = 7; i >= 1; i--) begin
            bus0.s_data = w[i];
            tick();
        end
        n_checks++; if (bus0.cnt !== 3'd7) begin n_fail++; $display("FAIL bp_cnt7: got %0d want 7", bus0.cnt); end
        n_checks++; if (bus0.p_data !== 8'hA5) begin n_fail++; $display("FAIL bp_hold: got %h want a5", bus0.p_data); end
        bus0.s_data = w[0];
        #1;
        n_checks++; if (bus0.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_sready_low: got %b want 0", bus0.s_ready); end
        tick();
        n_checks++; if (bus0.cnt !== 3'd7) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 7", bus0.cnt); end
        n_checks++; if (bus0.p_data !== 8'hA5) begin n_fail++; $display("FAIL bp_stall_data: got %h want a5", bus0.p_data); end
        bus0.p_ready = 1'b1;
        #1;
        n_checks++; if (bus0.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_sready_release: got %b want 1", bus0.s_ready); end
        tick();
        n_checks++; if (bus0.p_valid !== 1'b1) begin n_fail++; $display("FAIL bp_new_valid: got %b want 1", bus0.p_valid); end
        n_checks++; if (bus0.p_data !== 8'h3C) begin n_fail++; $display("FAIL bp_new_data: got %h want 3c", bus0.p_data); end
        n_checks++; if (bus0.cnt !== 3'd0) begin n_fail++; $display("FAIL bp_cnt0: got %0d want 0", bus0.cnt); end
        bus0.s_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        w = 8'h0F;
        bus0.p_ready = 1'b1;
        send_word0(8'h5A);
        n_checks++; if (bus0.p_data !== 8'h5A || bus0.p_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_word1: got %b/%h want 1/5a", bus0.p_valid, bus0.p_data); end
        send_word0(8'hC3);
        n_checks++; if (bus0.p_data !== 8'hC3 || bus0.p_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_word2: got %b/%h want 1/c3", bus0.p_valid, bus0.p_data); end
        // Holder stays full while the next frame assembles, then swaps with no bubble.
        bus0.p_ready = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            bus0.s_data = w[i];
            tick();
            n_checks++; if (bus0.p_valid !== 1'b1 || bus0.p_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_hold bit %0d: got %b/%h want 1/c3", i, bus0.p_valid, bus0.p_data); end
        end
        bus0.p_ready = 1'b1;
        bus0.s_data  = w[0];
        tick();
        n_checks++; if (bus0.p_valid !== 1'b1 || bus0.p_data !== 8'h0F) begin n_fail++; $display("FAIL b2b_swap: got %b/%h want 1/0f", bus0.p_valid, bus0.p_data); end
        bus0.s_valid = 1'b0;
        tick();
        n_checks++; if (bus0.p_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus0.p_valid); end
    endtask

    task automatic test_reset_mid();
        bus0.p_ready = 1'b0;
        send_word0(8'h96);
        for (int i = 0; i < 3; i++) begin
            bus0.s_data = 1'b1;
            tick();
        end
        bus0.s_valid = 1'b0;
        n_checks++; if (bus0.cnt !== 3'd3 || bus0.p_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got cnt %0d valid %b want 3/1", bus0.cnt, bus0.p_valid); end
        arst0 = 1'b1;
        #1;
        n_checks++; if (bus0.cnt !== 3'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", bus0.cnt); end
        n_checks++; if (bus0.p_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pvalid: got %b want 0", bus0.p_valid); end
        n_checks++; if (bus0.p_data !== 8'h00) begin n_fail++; $display("FAIL arst_pdata: got %h want 00", bus0.p_data); end
        arst0 = 1'b0;
        bus0.p_ready = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = 1'b1;
            tick();
        end
        n_checks++; if (bus0.cnt !== 3'd7) begin n_fail++; $display("FAIL arst_new_frame: got %0d want 7", bus0.cnt); end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        bus0.s_valid = 1'b0;
        n_checks++; if (bus0.cnt !== 3'd0) begin n_fail++; $display("FAIL srst_cnt: got %0d want 0", bus0.cnt); end
        n_checks++; if (bus0.p_valid !== 1'b0 || bus0.p_data !== 8'h00) begin n_fail++; $display("FAIL srst_word: got %b/%h want 0/00", bus0.p_valid, bus0.p_data); end
        send_word0(8'h69);
        bus0.s_valid = 1'b0;
        n_checks++; if (bus0.p_valid !== 1'b1 || bus0.p_data !== 8'h69) begin n_fail++; $display("FAIL srst_after: got %b/%h want 1/69", bus0.p_valid, bus0.p_data); end
        tick();
    endtask

    task automatic test_cke();
        logic [7:0] w;
        w = 8'hB7;
        bus0.p_ready = 1'b0;
        send_word0(8'hE1);
        for (int i = 7; i >= 5; i--) begin
            bus0.s_data = w[i];
            tick();
        end
        n_checks++; if (bus0.cnt !== 3'd3) begin n_fail++; $display("FAIL cke_pre_cnt: got %0d want 3", bus0.cnt); end
        cke0 = 1'b0;
        bus0.p_ready = 1'b1;
        bus0.s_data  = w[4];
        #1;
        n_checks++; if (bus0.s_ready !== 1'b0) begin n_fail++; $display("FAIL cke_sready: got %b want 0", bus0.s_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (bus0.cnt !== 3'd3 || bus0.p_valid !== 1'b1 || bus0.p_data !== 8'hE1) begin n_fail++; $display("FAIL cke_frozen cycle %0d: got %0d/%b/%h want 3/1/e1", i, bus0.cnt, bus0.p_valid, bus0.p_data); end
        end
        cke0 = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            bus0.s_data = w[i];
            tick();
        end
        bus0.s_valid = 1'b0;
        n_checks++; if (bus0.p_valid !== 1'b1 || bus0.p_data !== 8'hB7) begin n_fail++; $display("FAIL cke_resume: got %b/%h want 1/b7", bus0.p_valid, bus0.p_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_cke();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
